// File: rtl/tetris_pkg.sv
// Shared definitions for the piece-movement scheduling logic: command codes,
// scheduler states, default timing constants and a saturating counter helper.
package tetris_pkg;

    localparam int halfSec = 25000000;
    localparam int oneSec  = 50000000;

    localparam logic [1:0] CMD_GRAV  = 2'd0;
    localparam logic [1:0] CMD_DOWN  = 2'd1;
    localparam logic [1:0] CMD_LEFT  = 2'd2;
    localparam logic [1:0] CMD_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_BLANK = 2'd1,
        ST_ISSUE      = 2'd2
    } sched_state_e;

    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [2:0] inc);
        logic [8:0] sum_s;
        sum_s = {1'b0, base} + {6'd0, inc};
        if (sum_s > 9'd255) begin
            sat_add8 = 8'd255;
        end else begin
            sat_add8 = sum_s[7:0];
        end
    endfunction

endpackage

// File: rtl/gravity_timer.sv
// Level-dependent gravity down-counter; raises a one-cycle expiry pulse while
// the count sits at zero and reloads so that expiries are exactly one period apart.
module gravity_timer
    import tetris_pkg::*;
#(
    parameter int TICK_BASE = halfSec,
    parameter int TICK_STEP = 2000000,
    parameter int TICK_MIN  = 5000000,
    parameter int LEVEL_W   = 4,
    parameter int CNT_W     = 26
) (
    input  logic               vclk,
    input  logic               rst,
    input  logic               frz,
    input  logic [LEVEL_W-1:0] level,
    output logic               expire
);

    localparam int PW = CNT_W + LEVEL_W;

    logic [PW-1:0]    prod_s;
    logic [PW-1:0]    diff_s;
    logic [PW-1:0]    period_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             expire_r;

    // Reload period: base minus level steps, floored; a wrap below zero also takes the floor
    always_comb begin
        prod_s = PW'(level) * PW'(TICK_STEP);
        diff_s = PW'(TICK_BASE) - prod_s;
        if (prod_s > PW'(TICK_BASE)) begin
            period_s = PW'(TICK_MIN);
        end else if (diff_s < PW'(TICK_MIN)) begin
            period_s = PW'(TICK_MIN);
        end else begin
            period_s = diff_s;
        end
    end

    // Zero always reloads (even under freeze) so an expiry coinciding with frz is kept
    always_comb begin
        if (cnt_r == {CNT_W{1'b0}}) begin
            cnt_nxt_s = CNT_W'(period_s - PW'(1));
        end else if (frz) begin
            cnt_nxt_s = cnt_r;
        end else begin
            cnt_nxt_s = cnt_r - CNT_W'(1);
        end
    end

    // Counter and registered expiry flag (high exactly while the count is zero)
    always_ff @(posedge vclk or negedge rst) begin
        if (!rst) begin
            cnt_r    <= CNT_W'(TICK_BASE);
            expire_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_nxt_s;
            expire_r <= (cnt_nxt_s == {CNT_W{1'b0}});
        end
    end

    assign expire = expire_r;

endmodule

// File: rtl/drop_scheduler.sv
// Captures gravity ticks and debounced move requests as pending flags and issues
// them one at a time on a valid/ready stream, only while the raster is blanked.
module drop_scheduler
    import tetris_pkg::*;
#(
    parameter int TICK_BASE = halfSec,
    parameter int TICK_STEP = 2000000,
    parameter int TICK_MIN  = 5000000,
    parameter int LEVEL_W   = 4,
    parameter int CNT_W     = 26
) (
    input  logic               vclk,
    input  logic               rst,
    input  logic               frz,
    input  logic               vblank,
    input  logic               left_req,
    input  logic               right_req,
    input  logic               down_req,
    input  logic [LEVEL_W-1:0] level,
    output logic               cmd_valid,
    output logic [1:0]         cmd,
    input  logic               cmd_ready,
    output logic [7:0]         drop_cnt
);

    sched_state_e state_r;
    sched_state_e state_nxt_s;

    // Pending flags and masks are indexed by command code
    logic [3:0] pend_r;
    logic [3:0] pend_nxt_s;
    logic [3:0] set_s;
    logic [3:0] clr_s;
    logic [3:0] grant_mask_s;
    logic [2:0] req_s;
    logic [2:0] req_prev_r;
    logic       grav_expire_s;
    logic       issue_s;
    logic       conflict_s;
    logic [1:0] grant_s;
    logic [2:0] drop_inc_s;
    logic       cmd_valid_r;
    logic [1:0] cmd_r;
    logic [7:0] drop_cnt_r;

    gravity_timer #(
        .TICK_BASE (TICK_BASE),
        .TICK_STEP (TICK_STEP),
        .TICK_MIN  (TICK_MIN),
        .LEVEL_W   (LEVEL_W),
        .CNT_W     (CNT_W)
    ) u_gravity_timer (
        .vclk   (vclk),
        .rst    (rst),
        .frz    (frz),
        .level  (level),
        .expire (grav_expire_s)
    );

    assign req_s        = {right_req, left_req, down_req};
    assign set_s        = {req_s & ~req_prev_r & {3{~frz}}, grav_expire_s};
    assign grant_mask_s = 4'b0001 << cmd_r;

    // Previous request levels; tracked even while frozen so no stale edge appears on thaw
    always_ff @(posedge vclk or negedge rst) begin
        if (!rst) begin
            req_prev_r <= 3'b000;
        end else begin
            req_prev_r <= req_s;
        end
    end

    // Scheduler state register
    always_ff @(posedge vclk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, arbitration with left/right conflict cancel, and grant clearing
    always_comb begin
        state_nxt_s = state_r;
        clr_s       = 4'b0000;
        issue_s     = 1'b0;
        conflict_s  = 1'b0;
        grant_s     = CMD_GRAV;
        case (state_r)
            ST_IDLE: begin
                if ((pend_r != 4'b0000) && !frz) begin
                    state_nxt_s = ST_WAIT_BLANK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT_BLANK: begin
                if (vblank && !frz) begin
                    if (pend_r[CMD_LEFT] && pend_r[CMD_RIGHT]) begin
                        conflict_s = 1'b1;
                        clr_s      = 4'b1100;
                        if (((pend_r & 4'b0011) | set_s) != 4'b0000) begin
                            state_nxt_s = ST_WAIT_BLANK;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end else if (pend_r[CMD_GRAV]) begin
                        issue_s     = 1'b1;
                        grant_s     = CMD_GRAV;
                        state_nxt_s = ST_ISSUE;
                    end else if (pend_r[CMD_DOWN]) begin
                        issue_s     = 1'b1;
                        grant_s     = CMD_DOWN;
                        state_nxt_s = ST_ISSUE;
                    end else if (pend_r[CMD_LEFT]) begin
                        issue_s     = 1'b1;
                        grant_s     = CMD_LEFT;
                        state_nxt_s = ST_ISSUE;
                    end else if (pend_r[CMD_RIGHT]) begin
                        issue_s     = 1'b1;
                        grant_s     = CMD_RIGHT;
                        state_nxt_s = ST_ISSUE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_WAIT_BLANK;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    clr_s = grant_mask_s;
                    if (((pend_r & ~grant_mask_s) | set_s) != 4'b0000) begin
                        state_nxt_s = ST_WAIT_BLANK;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Flag update (a set beats a same-cycle clear) and the number of requests lost this cycle
    always_comb begin
        pend_nxt_s = (pend_r & ~clr_s) | set_s;
        if (conflict_s) begin
            drop_inc_s = 3'd2;
        end else begin
            drop_inc_s = 3'd0;
        end
        for (int i = 0; i < 4; i++) begin
            if (set_s[i] && pend_r[i] && !clr_s[i]) begin
                drop_inc_s = drop_inc_s + 3'd1;
            end else begin
                drop_inc_s = drop_inc_s;
            end
        end
    end

    // Pending flags, drop counter and the registered command interface
    always_ff @(posedge vclk or negedge rst) begin
        if (!rst) begin
            pend_r      <= 4'b0000;
            drop_cnt_r  <= 8'd0;
            cmd_valid_r <= 1'b0;
            cmd_r       <= CMD_GRAV;
        end else begin
            pend_r     <= pend_nxt_s;
            drop_cnt_r <= sat_add8(drop_cnt_r, drop_inc_s);
            if (issue_s) begin
                cmd_valid_r <= 1'b1;
                cmd_r       <= grant_s;
            end else if ((state_r == ST_ISSUE) && cmd_ready) begin
                cmd_valid_r <= 1'b0;
            end else begin
                cmd_valid_r <= cmd_valid_r;
            end
        end
    end

    assign cmd_valid = cmd_valid_r;
    assign cmd       = cmd_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: doc/drop_scheduler.md
Name: drop_scheduler

Overview:
- Sequences every piece-movement command sent to the game-logic datapath.
- Generates the level-dependent gravity tick and latches debounced LEFT/RIGHT/DOWN requests.
- Arbitrates those requests into a single valid/ready command stream, released only during vertical blanking so a frame is never drawn mid-move.
- Sits between the button debouncers and the game logic, all in the vclk (50 MHz) domain.

Parameters:
- TICK_BASE, 25000000: gravity period in vclk cycles at level 0 (0.5 s).
- TICK_STEP, 2000000: period reduction per level.
- TICK_MIN, 5000000: floor on gravity period.
- LEVEL_W, 4: width of the level input.
- CNT_W, 26: gravity counter width.

Ports:
- vclk, input, 1: pixel/system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- frz, input, 1: pause; level-sensitive.
- vblank, input, 1: high while the raster is outside the 800x600 visible area.
- left_req, input, 1: debounced LEFT, level.
- right_req, input, 1: debounced RIGHT, level.
- down_req, input, 1: debounced DOWN, level.
- level, input, LEVEL_W: current game level.
- cmd_valid, output, 1: command presented.
- cmd, output, 2: command code. 0 = GRAV, 1 = DOWN, 2 = LEFT, 3 = RIGHT.
- cmd_ready, input, 1: game logic accepts cmd this cycle.
- drop_cnt, output, 8: saturating count of coalesced (lost) requests.

Behaviour:
- Reset (rst=0, async):
  - cmd_valid=0, cmd=0, drop_cnt=0.
  - Pending flags cleared; edge-detect registers cleared.
  - Gravity counter loaded with TICK_BASE; state IDLE.
- Request capture:
  - Each *_req is rising-edge detected (registered previous value). An edge sets the matching pending flag P_DOWN/P_LEFT/P_RIGHT one cycle later.
  - Edge while the flag is already set: flag stays set, drop_cnt += 1, saturating at 255.
- Gravity:
  - Down-counter decrements each cycle while frz=0.
  - At 0 it sets P_GRAV and reloads with period = max(TICK_BASE - level*TICK_STEP, TICK_MIN).
  - Period computation uses CNT_W+LEVEL_W bits; an underflow is treated as TICK_MIN.
  - A level change takes effect only at the next reload.
  - P_GRAV already set at expiry: drop_cnt += 1.
- Freeze (frz=1):
  - Counter holds its value; no edges are captured and the edge-detect registers keep updating.
  - Pending flags are retained.
  - No new command is issued; a command already presented completes its handshake.
- Left/right conflict: P_LEFT and P_RIGHT both set at arbitration → both cleared, no command issued, drop_cnt += 2 (saturating).
- Priority: GRAV > DOWN > LEFT > RIGHT, fixed.
- FSM states:
  - IDLE: any flag set and frz=0 → WAIT_BLANK.
  - WAIT_BLANK: when vblank=1 and frz=0, arbitrate. Register cmd, set cmd_valid=1 next cycle → ISSUE. If the conflict rule empties all flags → IDLE.
  - ISSUE: cmd_valid=1 and cmd stable until cmd_ready=1.
    - On the handshake cycle, clear the granted flag and deassert cmd_valid next cycle.
    - Go to WAIT_BLANK if flags remain, else IDLE.
    - vblank falling during ISSUE does not withdraw the command.
- Throughput and latency:
  - At most one command per handshake; back-to-back commands are possible within one blanking interval.
  - Latency from request edge to cmd_valid is 3 cycles minimum when vblank=1.
- Simultaneous events:
  - A flag set and its own grant clear in the same cycle: the set wins; the flag stays set and no drop is counted.
  - Gravity expiry while frz asserts in the same cycle: the expiry is honoured.
- Reset mid-handshake: cmd_valid drops immediately (async) and all pending work is discarded.

Decomposition:
- Shared package tetris_pkg:
  - Command code constants CMD_GRAV/CMD_DOWN/CMD_LEFT/CMD_RIGHT.
  - FSM state encodings.
  - Default timing constants: halfSec = 25000000 and oneSec = 50000000.
- One sub-module, gravity_timer: counter, reload arithmetic and frz hold; outputs a 1-cycle expiry pulse.
- Arbiter and FSM live in drop_scheduler.

Test Plan (sim with TICK_BASE=100, TICK_STEP=10, TICK_MIN=30):
1. Release reset, level=0, vblank=1, cmd_ready=1 → cmd_valid with cmd=0 exactly once every 100 cycles; drop_cnt=0.
2. level=9 → after the next reload the period is max(100-90, 30) = 30 cycles. With level=3 the period is 70.
3. left_req pulse during vblank=0, vblank rises 50 cycles later → no cmd_valid before vblank. cmd=2 appears 1 cycle after vblank rises; held while cmd_ready=0 across the vblank fall; clears one cycle after cmd_ready=1.
4. left_req and right_req edges with no grant in between → no command issued, drop_cnt=2. Gravity expiry coinciding with a down_req edge → cmd=0 then cmd=1 on consecutive handshakes.
5. frz=1 for 500 cycles with counter at 40 → counter holds at 40 and no command is issued. A command already presented completes on cmd_ready=1. After frz=0, expiry occurs 40 cycles later.
6. Three down_req edges while cmd_ready=0 → one DOWN issued after ready, drop_cnt=2. rst=0 asserted mid-ISSUE → cmd_valid=0 within the same cycle, drop_cnt=0.
